// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Each grant takes IDLE -> ACCESS -> ACK; out-of-range addresses complete with err.
module dm_arbiter #(
    parameter int unsigned DEPTH    = 100,
    parameter logic [31:0] ERR_CODE = 32'hDEAD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wd0,
    input  logic [31:0] wd1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic        err0,
    output logic        err1,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ACK    = 2'd2;

    localparam logic [31:0] LIMIT = 32'(DEPTH);

    logic [1:0]  state;
    logic        sel;
    logic        prio;
    logic        win;
    logic        cur_we;
    logic        in_range;
    logic        in_access;
    logic [31:0] cur_addr;
    logic [31:0] cur_wd;
    logic [31:0] rsp;

    // prio only matters when both ports ask at once
    assign win       = (req0 && req1) ? prio : req1;
    assign cur_addr  = sel ? addr1 : addr0;
    assign cur_wd    = sel ? wd1 : wd0;
    assign cur_we    = sel ? we1 : we0;
    assign in_range  = cur_addr < LIMIT;
    assign in_access = (state == ACCESS);
    assign rsp       = in_range ? mem_rd : ERR_CODE;

    assign mem_we   = in_access && cur_we && in_range;
    assign mem_addr = in_access ? cur_addr : '0;
    assign mem_wd   = in_access ? cur_wd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= 1'b0;
            prio   <= 1'b0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
            rdata0 <= '0;
            rdata1 <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel   <= win;
                        prio  <= ~win;
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= ACK;
                    if (sel) begin
                        ack1   <= 1'b1;
                        err1   <= ~in_range;
                        rdata1 <= rsp;
                    end else begin
                        ack0   <= 1'b1;
                        err0   <= ~in_range;
                        rdata0 <= rsp;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural data memory.
// Expected responses come from a shadow copy of memory updated at issue time.
module tb_dm_arbiter;

    localparam int DEPTH = 100;
    localparam logic [31:0] ERRC = 32'hDEAD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cnt = 0;
    logic [31:0] we_last_addr = '0;

    logic [31:0] mem    [0:DEPTH-1];
    logic [31:0] shadow [0:DEPTH-1];
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int log_port[$];
    int log_cyc[$];

    always #5 clk = ~clk;

    dm_arbiter #(.DEPTH(DEPTH), .ERR_CODE(ERRC)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wd0(wd0), .wd1(wd1),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    assign mem_rd = (mem_addr < DEPTH) ? mem[mem_addr[6:0]] : 32'h0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (mem_we && mem_addr < DEPTH) mem[mem_addr[6:0]] <= mem_wd;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (rst_n) begin
            if (mem_we) begin
                we_cnt = we_cnt + 1;
                we_last_addr = mem_addr;
            end
            if (ack0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL ack0_unexpected got ack0=1 want no ack");
                end else begin
                    e = q0.pop_front();
                    if ({err0, rdata0} !== e) begin
                        errors++;
                        $display("FAIL port0_resp got err=%b rdata=%h want err=%b rdata=%h",
                                 err0, rdata0, e[32], e[31:0]);
                    end
                end
            end
            if (ack1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL ack1_unexpected got ack1=1 want no ack");
                end else begin
                    e = q1.pop_front();
                    if ({err1, rdata1} !== e) begin
                        errors++;
                        $display("FAIL port1_resp got err=%b rdata=%h want err=%b rdata=%h",
                                 err1, rdata1, e[32], e[31:0]);
                    end
                end
            end
            checks++;
            if ((err0 && !ack0) || (err1 && !ack1) || (ack0 && ack1)) begin
                errors++;
                $display("FAIL ack_err_excl got ack=%b%b err=%b%b want err only with ack, one ack",
                         ack0, ack1, err0, err1);
            end
        end
    end

    task automatic push_exp(input bit port, input bit we, input logic [31:0] a,
                            input logic [31:0] d);
        logic [32:0] e;
        if (a < DEPTH) begin
            e = {1'b0, shadow[a[6:0]]};
            if (we) shadow[a[6:0]] = d;
        end else begin
            e = {1'b1, ERRC};
        end
        if (port) q1.push_back(e);
        else q0.push_back(e);
    endtask

    task automatic issue(input bit port, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
        push_exp(port, we, a, d);
        if (port) begin
            we1 = we; addr1 = a; wd1 = d; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = a; wd0 = d; req0 = 1'b1;
        end
    endtask

    // run until both ports are released and the scoreboard is empty
    task automatic drain(input int budget);
        int n = 0;
        log_port.delete();
        log_cyc.delete();
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (ack0) begin
                req0 = 1'b0; log_port.push_back(0); log_cyc.push_back(cyc);
            end
            if (ack1) begin
                req1 = 1'b0; log_port.push_back(1); log_cyc.push_back(cyc);
            end
            if (!req0 && !req1 && q0.size() == 0 && q1.size() == 0) break;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout got pending q0=%0d q1=%0d want 0 0",
                     q0.size(), q1.size());
            req0 = 1'b0; req1 = 1'b0;
            q0.delete(); q1.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        q0.delete(); q1.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ack0, ack1, err0, err1} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got %b%b%b%b want 0000", ack0, ack1, err0, err1);
        end
        checks++;
        if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h %h want 0 0", rdata0, rdata1);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem got we=%b a=%h d=%h want 0 0 0", mem_we, mem_addr, mem_wd);
        end
    endtask

    task automatic test_write_read();
        int start, cnt0;
        cnt0 = we_cnt;
        start = cyc;
        issue(0, 1, 32'd5, 32'h1234);
        drain(20);
        checks++;
        if (log_cyc.size() != 1 || log_cyc[0] - start != 2) begin
            errors++;
            $display("FAIL write_latency got %0d acks want ack 2 cycles after req", log_cyc.size());
        end
        checks++;
        if (we_cnt - cnt0 != 1 || we_last_addr !== 32'd5) begin
            errors++;
            $display("FAIL write_memwe got cnt=%0d addr=%h want 1 5", we_cnt - cnt0, we_last_addr);
        end
        issue(0, 0, 32'd5, 32'h0);
        drain(20);
        checks++;
        if (rdata0 !== 32'h1234 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL read_back got %h err=%b want 00001234 0", rdata0, err0);
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int ports[$];
        int cycs[$];
        do_reset();
        push_exp(0, 0, 32'd5, 32'h0);
        push_exp(0, 0, 32'd5, 32'h0);
        push_exp(1, 0, 32'd6, 32'h0);
        push_exp(1, 0, 32'd6, 32'h0);
        we0 = 0; addr0 = 32'd5; we1 = 0; addr1 = 32'd6;
        req0 = 1'b1; req1 = 1'b1;
        while (n < 40 && ports.size() < 4) begin
            @(negedge clk);
            n++;
            if (ack0) begin ports.push_back(0); cycs.push_back(cyc); end
            if (ack1) begin ports.push_back(1); cycs.push_back(cyc); end
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (ports.size() != 4) begin
            errors++;
            $display("FAIL rr_count got %0d acks want 4", ports.size());
            q0.delete(); q1.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ports[i] != (i % 2)) begin
                    errors++;
                    $display("FAIL rr_order[%0d] got port %0d want %0d", i, ports[i], i % 2);
                end
            end
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (cycs[i] - cycs[i-1] != 3) begin
                    errors++;
                    $display("FAIL rr_spacing[%0d] got %0d want 3", i, cycs[i] - cycs[i-1]);
                end
            end
        end
        drain(20);
    endtask

    task automatic test_out_of_range();
        int cnt0;
        issue(1, 0, 32'd100, 32'h0);
        drain(20);
        issue(1, 0, 32'd99, 32'h0);
        drain(20);
        issue(1, 0, 32'hFFFF_FFFF, 32'h0);
        drain(20);
        cnt0 = we_cnt;
        issue(1, 1, 32'd150, 32'h5A5A);
        drain(20);
        checks++;
        if (we_cnt != cnt0) begin
            errors++;
            $display("FAIL oor_write_memwe got %0d strobes want 0", we_cnt - cnt0);
        end
        issue(1, 1, 32'h8000_0003, 32'h77);
        drain(20);
        checks++;
        if (we_cnt != cnt0 || mem[3] !== shadow[3]) begin
            errors++;
            $display("FAIL oor_high_bit got cnt=%0d mem3=%h want 0 %h", we_cnt - cnt0, mem[3], shadow[3]);
        end
    endtask

    task automatic test_late_req();
        issue(0, 0, 32'd5, 32'h0);
        @(negedge clk);
        issue(1, 1, 32'd11, 32'hBEEF);
        drain(30);
        checks++;
        if (log_port.size() != 2 || log_port[0] != 0 || log_port[1] != 1 ||
            log_cyc[1] - log_cyc[0] != 3) begin
            errors++;
            $display("FAIL late_req got %0d acks gap=%0d want port0 then port1 gap 3",
                     log_port.size(),
                     log_cyc.size() == 2 ? log_cyc[1] - log_cyc[0] : -1);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        we0 = 1; addr0 = 32'd9; wd0 = 32'h5555; req0 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'd9) begin
            errors++;
            $display("FAIL mid_access_we got we=%b a=%h want 1 9", mem_we, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
            errors++;
            $display("FAIL rst_memwe got we=%b a=%h d=%h want 0 0 0", mem_we, mem_addr, mem_wd);
        end
        checks++;
        if ({ack0, ack1, err0, err1} !== 4'b0 || rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL rst_outputs got %b%b%b%b %h %h want all 0",
                     ack0, ack1, err0, err1, rdata0, rdata1);
        end
        req0 = 1'b0;
        q0.delete(); q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(0, 0, 32'd9, 32'h0);
        issue(1, 0, 32'd5, 32'h0);
        drain(30);
        checks++;
        if (log_port.size() != 2 || log_port[0] != 0) begin
            errors++;
            $display("FAIL rst_prio got first=%0d want 0",
                     log_port.size() > 0 ? log_port[0] : -1);
        end
    endtask

    task automatic test_isolation();
        logic [31:0] keep;
        int n = 0;
        keep = shadow[5];
        issue(1, 0, 32'd5, 32'h0);
        drain(20);
        issue(0, 1, 32'd7, 32'hAAAA);
        while (n < 20 && req0) begin
            @(negedge clk);
            n++;
            checks++;
            if (ack1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== keep) begin
                errors++;
                $display("FAIL iso_port1 got ack=%b err=%b rdata=%h want 0 0 %h",
                         ack1, err1, rdata1, keep);
            end
            if (ack0) req0 = 1'b0;
        end
        drain(20);
        issue(1, 0, 32'd7, 32'h0);
        drain(20);
        checks++;
        if (rdata1 !== 32'hAAAA) begin
            errors++;
            $display("FAIL iso_readback got %h want 0000aaaa", rdata1);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'h0;
            shadow[i] = 32'h0;
        end
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_late_req();
        test_reset_mid_access();
        test_isolation();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter DEPTH, default 100, number of valid data-memory words (addresses 0..DEPTH-1).
REQ-002 Parameter ERR_CODE, default 32'hDEAD, read data returned for an out-of-range access.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0 / req1  input  1 each  access request, port 0 (CPU) / port 1 (DMA); held high until acked.
REQ-006 we0 / we1  input  1 each  1 = write, 0 = read; held stable while req high.
REQ-007 addr0 / addr1  input  32 each  word address; held stable while req high.
REQ-008 wd0 / wd1  input  32 each  write data; held stable while req high.
REQ-009 ack0 / ack1  output  1 each  registered one-cycle completion pulse.
REQ-010 rdata0 / rdata1  output  32 each  registered read result, valid from the ack cycle until that port's next ack.
REQ-011 err0 / err1  output  1 each  registered; high with ack when the address was out of range.
REQ-012 mem_we  output  1  write enable to the data memory.
REQ-013 mem_addr  output  32  address to the data memory.
REQ-014 mem_wd  output  32  write data to the data memory.
REQ-015 mem_rd  input  32  combinational read data from the data memory.

Function
REQ-016 FSM states SHALL be IDLE, ACCESS, ACK; reset state IDLE.
REQ-017 IDLE: no request -> stay IDLE; any request -> latch winner id into sel, go ACCESS.
REQ-018 Arbitration: one request -> that port wins; both -> port named by priority pointer prio wins.
REQ-019 After each grant, prio SHALL point to the port that did not win (round-robin); prio unchanged when no grant.
REQ-020 ACCESS lasts exactly one cycle: mem_addr = addr[sel], mem_wd = wd[sel], mem_we = we[sel] AND (addr[sel] < DEPTH).
REQ-021 Outside ACCESS: mem_we = 0; mem_addr and mem_wd = 0.
REQ-022 At ACCESS->ACK edge: rdata[sel] <= (addr in range ? mem_rd : ERR_CODE); err[sel] <= (addr >= DEPTH); ack[sel] <= 1.
REQ-023 Writes SHALL also capture rdata: mem_rd for in-range (pre-write content), ERR_CODE for out-of-range.
REQ-024 Out-of-range write SHALL NOT assert mem_we and SHALL still complete with ack and err.
REQ-025 ACK lasts exactly one cycle: ack[sel] high, no arbitration, then IDLE unconditionally.
REQ-026 The non-selected port's ack, err and rdata SHALL be unchanged by the transaction.
REQ-027 err[x] SHALL be high only in a cycle in which ack[x] is high; otherwise 0.
REQ-028 Latency: req sampled high at edge N (FSM in IDLE) -> ACCESS cycle after N, ack high in cycle after N+1; next grant earliest at edge N+3.
REQ-029 Requests arriving in ACCESS or ACK SHALL wait; they are arbitrated in the next IDLE.
REQ-030 A requester that keeps req high after ack SHALL be treated as a new request.
REQ-031 Address comparison SHALL be unsigned over all 32 bits.

Reset
REQ-032 rst_n low SHALL immediately force: state IDLE, prio = port 0, sel = 0, ack0 = ack1 = 0, err0 = err1 = 0, rdata0 = rdata1 = 0.
REQ-033 Reset during ACCESS SHALL deassert mem_we immediately; the in-flight transaction is dropped with no ack.
REQ-034 First edge after rst_n rises SHALL arbitrate normally from IDLE.

Verification
REQ-035 Port 0 writes 32'h1234 to addr 5, then reads addr 5 -> mem_we high one cycle with mem_addr 5; read ack0 with rdata0 = 32'h1234, err0 = 0.
REQ-036 req0 and req1 rise together, held -> grants alternate 0,1,0,1 after reset; each ack 3 cycles apart.
REQ-037 Port 1 reads addr 100 (DEPTH 100) -> ack1 with rdata1 = 32'hDEAD, err1 = 1; write to addr 150 -> mem_we never high, err1 = 1.
REQ-038 req1 rises during port 0 ACCESS -> port 1 served in next IDLE; ack1 exactly 3 cycles after ack0.
REQ-039 rst_n low during ACCESS of a write -> mem_we drops same cycle, no ack, all outputs 0, prio = 0.
REQ-040 Port 0 write of 32'hAAAA to addr 7 while port 1 idle -> rdata1, ack1, err1 unchanged; port 1 read addr 7 -> 32'hAAAA.
